// File: rtl/opm_seq_pkg.sv
// Shared types and constants for the OPM write sequencer.
package opm_seq_pkg;

  // Default parameter values.
  localparam int DEF_DEPTH        = 16;
  localparam int DEF_WR_PULSE     = 4;
  localparam int DEF_GAP          = 2;
  localparam int DEF_SETTLE       = 16;
  localparam int DEF_BUSY_TIMEOUT = 1024;

  // Bit positions inside the host status byte.
  localparam int STAT_BUSY    = 7;
  localparam int STAT_FULL    = 6;
  localparam int STAT_OVF     = 5;
  localparam int STAT_TIMEOUT = 4;

  // Busy flag position inside the OPM status byte.
  localparam int OPM_BUSY_BIT = 7;

  // Sequencer states. ST_ prefix keeps GAP/SETTLE free for the timing parameters.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP,
    ST_DATA,
    ST_SETTLE,
    ST_POLL
  } state_t;

  // One queued OPM register write.
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count. Pushes while full and
// pops while empty are ignored; fullness is judged before a same-cycle pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array write.
  // NOTE: the data array is deliberately left out of reset; only the pointers
  // and count define validity, and unreset storage maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: sequential state always uses non-blocking assignment so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/opm_write_sequencer.sv
// Queues host {address, data} writes and replays each one onto the OPM bus as
// an address write, a gap, a data write, a settle period and a busy poll.
module opm_write_sequencer
  import opm_seq_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int WR_PULSE     = DEF_WR_PULSE,
  parameter int GAP          = DEF_GAP,
  parameter int SETTLE       = DEF_SETTLE,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       host_we,
  input  logic       host_re,
  input  logic       host_a0,
  input  logic [7:0] host_din,
  output logic [7:0] host_dout,
  output logic       opm_cs_n,
  output logic       opm_wr_n,
  output logic       opm_rd_n,
  output logic       opm_a0,
  output logic [7:0] opm_d,
  input  logic [7:0] opm_status
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int TMAX = max_int(max_int(WR_PULSE, GAP), max_int(SETTLE, BUSY_TIMEOUT));
  localparam int TW   = $clog2(max_int(TMAX, 2));

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  entry_t        entry_q, entry_d;
  entry_t        fifo_head;
  logic [7:0]    hold_q;
  logic          ovf_q;
  logic          timeout_q;
  logic          push_req;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          timeout_set;
  logic          busy;
  logic          cs_n_d, wr_n_d, rd_n_d, a0_d;
  logic [7:0]    d_d;
  logic          unused_status;

  assign push_req      = host_we && host_a0;
  assign busy          = opm_status[OPM_BUSY_BIT];
  assign unused_status = ^opm_status[OPM_BUSY_BIT-1:0];

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_req),
    .pop    (fifo_pop),
    .din    ({hold_q, host_din}),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Host status byte, assembled combinationally from live state.
  always_comb begin
    host_dout               = '0;
    host_dout[STAT_BUSY]    = !fifo_empty || (state_q != ST_IDLE);
    host_dout[STAT_FULL]    = fifo_full;
    host_dout[STAT_OVF]     = ovf_q;
    host_dout[STAT_TIMEOUT] = timeout_q;
    host_dout[3:0]          = 4'(fifo_count);
  end

  // Next-state, phase timer and next bus values. Bus outputs are a function of
  // the next state so the registered strobes line up with the state register.
  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fifo_pop    = 1'b0;
    timeout_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ADDR;
          cnt_d    = '0;
        end
      end
      ST_ADDR: begin
        if (cnt_q == TW'(WR_PULSE - 1)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == TW'(GAP - 1)) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == TW'(WR_PULSE - 1)) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == TW'(SETTLE - 1)) begin
          state_d = ST_POLL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_POLL: begin
        // Leaving POLL dispatches the next queued entry directly so that
        // back-to-back writes lose no cycle in IDLE.
        if (!busy || (cnt_q == TW'(BUSY_TIMEOUT - 1))) begin
          timeout_set = busy;
          cnt_d       = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    entry_d = fifo_pop ? fifo_head : entry_q;

    cs_n_d = 1'b1;
    wr_n_d = 1'b1;
    rd_n_d = 1'b1;
    a0_d   = opm_a0;
    d_d    = opm_d;
    case (state_d)
      ST_ADDR: begin
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
        a0_d   = 1'b0;
        d_d    = entry_d.addr;
      end
      ST_DATA: begin
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
        a0_d   = 1'b1;
        d_d    = entry_d.data;
      end
      ST_POLL: begin
        cs_n_d = 1'b0;
        rd_n_d = 1'b0;
        a0_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM state, phase timer, working entry and registered OPM bus.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      entry_q  <= '0;
      opm_cs_n <= 1'b1;
      opm_wr_n <= 1'b1;
      opm_rd_n <= 1'b1;
      opm_a0   <= 1'b0;
      opm_d    <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      entry_q  <= entry_d;
      opm_cs_n <= cs_n_d;
      opm_wr_n <= wr_n_d;
      opm_rd_n <= rd_n_d;
      opm_a0   <= a0_d;
      opm_d    <= d_d;
    end
  end

  // Address holding register and sticky flags; a set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_q    <= 8'h00;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (host_we && !host_a0) hold_q <= host_din;
      if (push_req && fifo_full) ovf_q <= 1'b1;
      else if (host_re)          ovf_q <= 1'b0;
      if (timeout_set)           timeout_q <= 1'b1;
      else if (host_re)          timeout_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_opm_write_sequencer.sv
// Directed bench for opm_write_sequencer: a bus monitor pops expected writes
// from a scoreboard queue filled as the host pushes.
module tb_opm_write_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       host_we = 1'b0;
  logic       host_re = 1'b0;
  logic       host_a0 = 1'b0;
  logic [7:0] host_din = 8'h00;
  logic [7:0] host_dout;
  logic       opm_cs_n, opm_wr_n, opm_rd_n, opm_a0;
  logic [7:0] opm_d;
  logic [7:0] opm_status = 8'h00;

  int          passed = 0;
  int          total = 0;
  logic [15:0] sb[$];
  logic [7:0]  hold_m = 8'h00;
  bit          mon_en = 1'b0;

  opm_write_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .host_we    (host_we),
    .host_re    (host_re),
    .host_a0    (host_a0),
    .host_din   (host_din),
    .host_dout  (host_dout),
    .opm_cs_n   (opm_cs_n),
    .opm_wr_n   (opm_wr_n),
    .opm_rd_n   (opm_rd_n),
    .opm_a0     (opm_a0),
    .opm_d      (opm_d),
    .opm_status (opm_status)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] mk(input logic cs, input logic wr, input logic rd,
                                     input logic a0, input logic [7:0] d);
    return {cs, wr, rd, a0, d};
  endfunction

  function automatic logic [11:0] bus();
    return {opm_cs_n, opm_wr_n, opm_rd_n, opm_a0, opm_d};
  endfunction

  // Called at a negedge; holds the strobe for one cycle and returns at the next negedge.
  task automatic host_write(input logic a0, input logic [7:0] din, input bit drop = 1'b0);
    host_we  = 1'b1;
    host_a0  = a0;
    host_din = din;
    if (!a0) hold_m = din;
    else if (!drop) sb.push_back({hold_m, din});
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_read();
    host_re = 1'b1;
    @(negedge clk);
    host_re = 1'b0;
  endtask

  task automatic expect_phase(input string tag, input int n, input logic [11:0] v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, bus(), v);
    end
  endtask

  // Bus monitor: measures write pulses and retires completed address/data pairs.
  int         wr_len = 0;
  logic       wr_a0;
  logic [7:0] wr_d;
  logic [7:0] got_addr = 8'h00;
  always @(negedge clk) begin
    if (!mon_en) begin
      wr_len = 0;
    end else begin
      check("rd_wr_exclusive", !(!opm_rd_n && !opm_wr_n), 1);
      if (!opm_wr_n) begin
        wr_len++;
        wr_a0 = opm_a0;
        wr_d  = opm_d;
      end else if (wr_len != 0) begin
        check("wr_pulse_len", wr_len, 4);
        if (!wr_a0) got_addr = wr_d;
        else if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
        else check("sb_entry", {got_addr, wr_d}, sb.pop_front());
        wr_len = 0;
      end
    end
  end

  initial begin
    int n;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_bus", bus(), mk(1, 1, 1, 0, 8'h00));
    check("reset_dout", host_dout, 8'h00);
    resetn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Single write with OPM ready.
    host_write(1'b0, 8'h28);
    check("addr_no_push", host_dout, 8'h00);
    host_write(1'b1, 8'h4A);
    check("push_cycle_bus", bus(), mk(1, 1, 1, 0, 8'h00));
    check("push_cycle_dout", host_dout, 8'h81);
    expect_phase("single_addr", 4, mk(0, 0, 1, 0, 8'h28));
    expect_phase("single_gap", 2, mk(1, 1, 1, 0, 8'h28));
    expect_phase("single_data", 4, mk(0, 0, 1, 1, 8'h4A));
    expect_phase("single_settle", 16, mk(1, 1, 1, 1, 8'h4A));
    expect_phase("single_poll", 1, mk(0, 1, 0, 1, 8'h4A));
    expect_phase("single_idle", 1, mk(1, 1, 1, 1, 8'h4A));
    check("single_dout_done", host_dout, 8'h00);

    // Busy held for 300 POLL cycles with three entries queued.
    opm_status = 8'h80;
    host_write(1'b0, 8'h10);
    host_write(1'b1, 8'h01);
    host_write(1'b1, 8'h02);
    host_write(1'b0, 8'h20);
    host_write(1'b1, 8'h03);
    n = 0;
    while (opm_rd_n && n < 100) begin @(negedge clk); n++; end
    check("hold_poll_reached", n < 100, 1);
    repeat (299) @(negedge clk);
    check("hold_still_polling", bus(), mk(0, 1, 0, 1, 8'h01));
    check("hold_dout_queued", host_dout, 8'h82);
    opm_status = 8'h00;
    @(negedge clk);
    check("hold_next_addr", bus(), mk(0, 0, 1, 0, 8'h10));
    n = 0;
    while (host_dout[7] && n < 200) begin @(negedge clk); n++; end
    check("hold_drain", n < 200, 1);
    check("hold_sb_empty", sb.size(), 0);

    // Overflow with busy stuck: 1 popped, 16 queued, 1 dropped.
    opm_status = 8'h80;
    host_write(1'b0, 8'h30);
    for (int i = 0; i < 18; i++) host_write(1'b1, 8'h80 + 8'(i), i == 17);
    check("ovf_dout", host_dout, 8'hE0);
    host_read();
    check("ovf_cleared", host_dout, 8'hC0);

    // Timeout: first entry times out; clear and time the second entry's POLL.
    n = 0;
    while (!(!opm_wr_n && opm_a0) && n < 1200) begin @(negedge clk); n++; end
    check("to_second_data", n < 1200, 1);
    check("to_first_set", host_dout[4], 1);
    host_read();
    check("to_cleared", host_dout[4], 0);
    n = 0;
    while (opm_rd_n && n < 100) begin @(negedge clk); n++; end
    check("to_poll_reached", n < 100, 1);
    n = 0;
    while (!opm_rd_n && n < 2000) begin @(negedge clk); n++; end
    check("to_poll_cycles", n, 1024);
    check("to_flag_set", host_dout[4], 1);
    check("to_next_addr", bus(), mk(0, 0, 1, 0, 8'h30));
    opm_status = 8'h00;
    n = 0;
    while (host_dout[7] && n < 1000) begin @(negedge clk); n++; end
    check("to_drain", n < 1000, 1);
    check("to_sb_empty", sb.size(), 0);
    host_read();

    // Reset during DATA aborts the write and discards the queue.
    host_write(1'b0, 8'h61);
    host_write(1'b1, 8'h11);
    host_write(1'b1, 8'h12);
    host_write(1'b1, 8'h13);
    n = 0;
    while (!(!opm_wr_n && opm_a0) && n < 50) begin @(negedge clk); n++; end
    check("rst_data_reached", n < 50, 1);
    resetn = 1'b0;
    mon_en = 1'b0;
    hold_m = 8'h00;
    @(negedge clk);
    check("rst_bus", bus(), mk(1, 1, 1, 0, 8'h00));
    check("rst_dout", host_dout, 8'h00);
    resetn = 1'b1;
    sb.delete();
    repeat (40) @(negedge clk);
    check("rst_queue_gone_bus", bus(), mk(1, 1, 1, 0, 8'h00));
    check("rst_queue_gone_dout", host_dout, 8'h00);
    mon_en = 1'b1;
    host_write(1'b1, 8'h55);
    n = 0;
    while (host_dout[7] && n < 100) begin @(negedge clk); n++; end
    check("rst_hold_drain", n < 100, 1);
    check("rst_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/opm_write_sequencer.md
OPM_WRITE_SEQUENCER -- requirements
Module: opm_write_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of {register address, data} entries in the write FIFO (power of two, at most 16).
REQ-002 The block SHALL have parameter WR_PULSE, default 4, meaning the number of clk cycles opm_cs_n and opm_wr_n are held low per OPM bus write.
REQ-003 The block SHALL have parameter GAP, default 2, meaning the number of clk cycles opm_cs_n is held high between the address write and the data write.
REQ-004 The block SHALL have parameter SETTLE, default 16, meaning the number of clk cycles after the data write during which OPM status is ignored.
REQ-005 The block SHALL have parameter BUSY_TIMEOUT, default 1024, meaning the maximum number of clk cycles spent polling for the OPM busy flag to clear.
REQ-006 The block SHALL have port clk, input, 1 bit: the single system clock (25 MHz).
REQ-007 The block SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-008 The block SHALL have port host_we, input, 1 bit: single-cycle host write strobe.
REQ-009 The block SHALL have port host_re, input, 1 bit: single-cycle host status-read strobe.
REQ-010 The block SHALL have port host_a0, input, 1 bit: 0 selects the address holding register, 1 selects data (push).
REQ-011 The block SHALL have port host_din, input, 8 bits: host write data.
REQ-012 The block SHALL have port host_dout, output, 8 bits: status byte (see REQ-016).
REQ-013 The block SHALL have ports opm_cs_n, opm_wr_n and opm_rd_n, each output, 1 bit: OPM bus strobes, all registered.
REQ-014 The block SHALL have ports opm_a0, output, 1 bit, and opm_d, output, 8 bits: OPM address select and write data, both registered.
REQ-015 The block SHALL have port opm_status, input, 8 bits: OPM read data, with bit 7 as the busy flag.

Function
REQ-016 host_dout SHALL be combinational: bit 7 = FIFO non-empty OR FSM not IDLE; bit 6 = full; bit 5 = sticky overflow; bit 4 = sticky timeout; bits 3:0 = count mod 16 (full is indicated by bit 6).
REQ-017 A host_we with host_a0=0 SHALL load host_din into the address holding register and SHALL NOT push.
REQ-018 A host_we with host_a0=1 SHALL push {holding register, host_din} when the FIFO is not full; the holding register SHALL be retained, so repeated data writes reuse the address.
REQ-019 A push attempted while full SHALL be dropped and SHALL set the overflow flag; fullness SHALL be evaluated before any same-cycle pop.
REQ-020 A host_re strobe SHALL clear the overflow and timeout flags after host_dout is sampled; if a set event and host_re occur in the same cycle, the set SHALL win.
REQ-021 FSM states SHALL be IDLE, ADDR, GAP, DATA, SETTLE and POLL.
REQ-022 IDLE → ADDR SHALL occur when the FIFO is non-empty, popping the head into a working register in the same cycle.
REQ-023 In ADDR: opm_cs_n=0, opm_wr_n=0, opm_a0=0, opm_d=address, for WR_PULSE cycles, then → GAP.
REQ-024 In GAP: all strobes high, for GAP cycles, then → DATA.
REQ-025 In DATA: opm_cs_n=0, opm_wr_n=0, opm_a0=1, opm_d=data, for WR_PULSE cycles, then → SETTLE.
REQ-026 In SETTLE: all strobes high, for SETTLE cycles, then → POLL.
REQ-027 In POLL: opm_cs_n=0, opm_rd_n=0, opm_a0=1; when opm_status[7]=0, the FSM SHALL go → IDLE.
REQ-028 If BUSY_TIMEOUT POLL cycles elapse with busy still set, the FSM SHALL set the timeout flag and go → IDLE.
REQ-029 With the FSM in IDLE and the FIFO empty, opm_cs_n SHALL fall exactly 2 cycles after the push strobe cycle.
REQ-030 Back-to-back queued entries SHALL begin ADDR on the cycle immediately after POLL exits.
REQ-031 Outside active states, opm_d SHALL hold its last value, and opm_wr_n and opm_rd_n SHALL never be low simultaneously.

Reset
REQ-032 While resetn=0 at a clk edge, the block SHALL set: FSM to IDLE, FIFO empty, count 0, holding register 0x00, flags 0, opm_cs_n/opm_wr_n/opm_rd_n = 1, opm_a0 = 0, opm_d = 0x00.
REQ-033 Reset asserted mid-transaction SHALL abort the transaction and discard all queued entries.

Structure
REQ-034 Package opm_seq_pkg SHALL hold the FSM state enum, status bit index constants and default parameter values.
REQ-035 The FIFO SHALL be a sub-module sync_fifo (parameterised width/depth, count output, push/pop, full/empty).

Verification
REQ-036 Single write: write a0=0 0x28, then a0=1 0x4A, with opm_status[7]=0 → ADDR cycle shows opm_d=0x28 for 4 cycles, GAP 2 cycles, DATA shows 0x4A for 4 cycles, SETTLE 16 cycles, POLL 1 cycle, then IDLE; host_dout bit 7 returns to 0.
REQ-037 Busy hold: keep opm_status[7]=1 for 300 cycles of POLL with 3 entries queued → the second ADDR starts exactly 1 cycle after busy drops; entries are issued in FIFO order.
REQ-038 Overflow: with busy stuck, push 18 entries → 1 popped plus 16 queued, 1 dropped; bit 6=1, bit 5=1; host_re → bit 5=0.
REQ-039 Timeout: busy stuck at 1 → after 1024 POLL cycles the timeout bit is set and the next entry starts.
REQ-040 Reset during DATA → at the next edge, strobes are high, count=0, host_dout=0x00.
